umi_decode_pipe: RTL and testbench
==================================

// Module: umi_decode_pipe
// PURPOSE
//  Registered, flow-controlled UMI command decoder. Sits between a UMI input port and the
//  endpoint/router logic. Accepts one packet per cycle, forwards it with a one-hot class
//  vector one cycle later, optionally drops INVALID opcodes, and keeps per-class
//  saturating transaction counters plus a sticky invalid-command error flag.
// PARAMETERS
//  CW             7    command width; opcode = {in_command, in_write}, so 8 bits at default
//  PW             256  opaque packet payload width (address, data and size fields), passed through
//  CNTW           16   statistics counter width
//  FILTER_INVALID 0    1: INVALID packets are accepted, counted and dropped (never reach out_*)
// PORTS
//  clk          in   1      clock
//  nreset       in   1      asynchronous active-low reset
//  in_valid     in   1      input packet valid
//  in_ready     out  1      input ready; registered, no combinational path from out_ready
//  in_command   in   CW     packet command
//  in_write     in   1      packet write bit
//  in_packet    in   PW     payload
//  out_valid    out  1      output valid
//  out_ready    in   1      downstream ready
//  out_command  out  CW     forwarded command
//  out_write    out  1      forwarded write bit
//  out_packet   out  PW     forwarded payload
//  out_decode   out  18     one-hot class flags; bit order listed under BEHAVIOUR
//  stat_sel     in   3      counter select: 0 rd, 1 posted, 2 ack, 3 wr_resp, 4 other wr, 5 atomic, 6 invalid, 7 total
//  stat_clear   in   1      synchronous clear of all counters
//  stat_count   out  CNTW   selected counter value; combinational mux of registers
//  err_invalid  out  1      sticky: set when an INVALID opcode is accepted
//  err_clear    in   1      synchronous clear of err_invalid
// BEHAVIOUR
//  - Reset values (nreset low): out_valid=0, in_ready=1, all counters=0, err_invalid=0.
//    out_command/out_write/out_packet/out_decode are 0.
//  - Decode map, index:flag: 0 invalid, 1 read_request, 2 write_posted, 3 write_signal,
//    4 write_ack, 5 write_stream, 6 write_response, 7 write_multicast, 8 atomic, 9 swap,
//    10 add, 11 and, 12 or, 13 xor, 14 min, 15 max, 16 minu, 17 maxu.
//  - Match rules use the umi_messages.vh constants.
//    - invalid, read_request and atomic subtypes compare the full 8-bit opcode.
//    - write_* classes and atomic compare opcode[3:0] only.
//    - Only the low 8 opcode bits are decoded; bits above 8 when CW>7 are ignored.
//  - Handshake: transfer when valid&&ready on either side. out_valid, once high, stays high
//    and out_* stay stable until out_ready.
//  - Pipeline: 2-entry skid buffer (main + skid register).
//    - Latency: 1 cycle from input acceptance to out_valid.
//    - Throughput: 1 packet/cycle while out_ready=1.
//    - If main is full and stalled while an input is accepted, the input goes to skid.
//    - in_ready <= !skid_full (registered).
//    - Skid drains into main on the next out_ready.
//    - Packet order is always preserved.
//  - FILTER_INVALID=1: an accepted INVALID packet is counted and dropped and occupies no
//    entry. in_ready is unaffected.
//  - Counters:
//    - Each class counter increments by 1 on input acceptance, not on output.
//    - Counter 4 counts signal|stream|multicast.
//    - Counter 7 counts every accepted packet.
//    - Counters saturate at {CNTW{1'b1}}.
//    - stat_clear has priority over a same-cycle increment: counter = 0.
//  - err_invalid is set on acceptance of INVALID. err_clear wins over a same-cycle set.
//  - nreset asserted mid-transfer: buffered packets are discarded and out_valid drops
//    asynchronously.
// TESTING
//  - Reset, then drive READ_REQUEST with out_ready=1 -> out_valid on the next cycle,
//    out_decode=18'h00002, stat_sel=0 reads 1, stat_sel=7 reads 1.
//  - 4 back-to-back WRITE_POSTED with out_ready=1 -> 4 outputs on consecutive cycles,
//    in_ready stays 1, counter 1 = 4.
//  - out_ready=0 while 3 packets are offered -> 2 accepted, in_ready=0 from the cycle after
//    the 2nd, out_* stable. Then out_ready=1 -> packets emerge in order and the 3rd is accepted.
//  - FILTER_INVALID=1, offer opcode 8'h00 -> no out_valid, counter 6 = 1, err_invalid=1.
//    err_clear pulse -> err_invalid=0.
//  - CNTW=4, 17 ATOMIC_ADD -> counter 5 = 4'hF (saturated), out_decode bits 8 and 10 set
//    on each output. stat_clear together with a valid ATOMIC_ADD -> counter = 0.
//  - Assert nreset with 2 packets buffered -> out_valid=0 immediately, in_ready=1, counters=0.

Source files
------------

// File: rtl/umi_decode_pipe.sv
// umi_decode_pipe: registered UMI command decoder with 2-entry skid buffer, class counters and sticky invalid flag
module umi_decode_pipe #(
  parameter int CW = 7,
  parameter int PW = 256,
  parameter int CNTW = 16,
  parameter bit FILTER_INVALID = 1'b0
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_command,
  input  logic            in_write,
  input  logic [PW-1:0]   in_packet,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_command,
  output logic            out_write,
  output logic [PW-1:0]   out_packet,
  output logic [17:0]     out_decode,
  input  logic [2:0]      stat_sel,
  input  logic            stat_clear,
  output logic [CNTW-1:0] stat_count,
  output logic            err_invalid,
  input  logic            err_clear
);
  localparam int W = CW + PW + 19;
  // umi_messages.vh opcodes ({command, write}); every atomic subtype shares the ATOMIC low nibble
  localparam logic [7:0] OP_INVALID = 8'h00, OP_READ = 8'h02;
  localparam logic [3:0] OP_POSTED = 4'h1, OP_ACK = 4'h3, OP_MULTICAST = 4'h5, OP_STREAM = 4'h7;
  localparam logic [3:0] OP_ATOMIC = 4'h9, OP_RESP_WRITE = 4'hB, OP_SIGNAL = 4'hD;
  localparam logic [7:0] OP_ADD = 8'h09, OP_AND = 8'h19, OP_OR = 8'h29, OP_XOR = 8'h39;
  localparam logic [7:0] OP_MAX = 8'h49, OP_MIN = 8'h59, OP_MAXU = 8'h69, OP_MINU = 8'h79, OP_SWAP = 8'h89;
  logic [7:0] op;
  logic [17:0] dec;
  logic [7:0] inc;
  logic accept, keep, skid_valid;
  logic [W-1:0] in_word, main_q, skid_q;
  logic [CNTW-1:0] cnt [8];
  assign op = {in_command[6:0], in_write};
  assign dec = {op == OP_MAXU, op == OP_MINU, op == OP_MAX, op == OP_MIN,
                op == OP_XOR, op == OP_OR, op == OP_AND, op == OP_ADD, op == OP_SWAP,
                op[3:0] == OP_ATOMIC, op[3:0] == OP_MULTICAST, op[3:0] == OP_RESP_WRITE,
                op[3:0] == OP_STREAM, op[3:0] == OP_ACK, op[3:0] == OP_SIGNAL,
                op[3:0] == OP_POSTED, op == OP_READ, op == OP_INVALID};
  assign accept = in_valid && in_ready;
  assign keep = accept && !(FILTER_INVALID && dec[0]);
  assign inc = {accept, accept & dec[0], accept & dec[8], accept & (dec[3] | dec[5] | dec[7]),
                accept & dec[6], accept & dec[4], accept & dec[2], accept & dec[1]};
  assign in_word = {in_command, in_write, in_packet, dec};
  assign {out_command, out_write, out_packet, out_decode} = main_q;
  assign stat_count = cnt[stat_sel];
  // main/skid pipeline; in_ready mirrors an empty skid so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_valid || keep;
      main_q <= skid_valid ? skid_q : keep ? in_word : main_q;
      skid_valid <= 1'b0;
      in_ready <= 1'b1;
    end else if (keep) begin
      skid_valid <= 1'b1;
      skid_q <= in_word;
      in_ready <= 1'b0;
    end
  // per-class saturating counters; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge nreset)
    if (!nreset)
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    else
      for (int k = 0; k < 8; k++) cnt[k] <= stat_clear ? '0 : (inc[k] && !(&cnt[k])) ? cnt[k] + 1'b1 : cnt[k];
  // sticky invalid flag; clear beats a same-cycle set
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) err_invalid <= 1'b0;
    else err_invalid <= err_clear ? 1'b0 : (accept && dec[0]) ? 1'b1 : err_invalid;
endmodule

// File: tb/tb_umi_decode_pipe.sv
// tb_umi_decode_pipe: directed scoreboard bench for a default decoder (a) and a filtering 4-bit-counter decoder (b)
module tb_umi_decode_pipe;
  localparam int CW = 7, PW = 256, W = CW + PW + 19;
  logic clk = 0, nreset = 0, in_valid = 0, in_write = 0, out_ready = 1, stat_clear = 0, err_clear = 0;
  logic [CW-1:0] in_command = '0;
  logic [PW-1:0] in_packet = '0;
  logic [2:0] stat_sel = '0;
  logic a_in_ready, a_out_valid, a_out_write, a_err, b_in_ready, b_out_valid, b_out_write, b_err;
  logic [CW-1:0] a_out_command, b_out_command;
  logic [PW-1:0] a_out_packet, b_out_packet, p1;
  logic [17:0] a_out_decode, b_out_decode;
  logic [15:0] a_cnt;
  logic [3:0] b_cnt;
  logic [W-1:0] qa[$], qb[$];
  logic acc;
  int tests = 0, fails = 0;
  logic [7:0] ops [18] = '{8'h02, 8'h01, 8'h0D, 8'h03, 8'h07, 8'h0B, 8'h05, 8'h89, 8'h19,
                           8'h29, 8'h39, 8'h59, 8'h49, 8'h79, 8'h69, 8'h11, 8'h1B, 8'h04};
  always #5 clk = ~clk;
  umi_decode_pipe u_a (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_command(in_command), .in_write(in_write), .in_packet(in_packet),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_command(a_out_command),
    .out_write(a_out_write), .out_packet(a_out_packet), .out_decode(a_out_decode),
    .stat_sel(stat_sel), .stat_clear(stat_clear), .stat_count(a_cnt),
    .err_invalid(a_err), .err_clear(err_clear));
  umi_decode_pipe #(.CNTW(4), .FILTER_INVALID(1'b1)) u_b (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_command(in_command), .in_write(in_write), .in_packet(in_packet),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_command(b_out_command),
    .out_write(b_out_write), .out_packet(b_out_packet), .out_decode(b_out_decode),
    .stat_sel(stat_sel), .stat_clear(stat_clear), .stat_count(b_cnt),
    .err_invalid(b_err), .err_clear(err_clear));
  function automatic logic [17:0] exp_dec(input logic [7:0] op);
    case (op)
      8'h00: return 18'h00001;
      8'h02: return 18'h00002;
      8'h01, 8'h11: return 18'h00004;
      8'h0D: return 18'h00008;
      8'h03: return 18'h00010;
      8'h07: return 18'h00020;
      8'h0B, 8'h1B: return 18'h00040;
      8'h05: return 18'h00080;
      8'h89: return 18'h00300;
      8'h09: return 18'h00500;
      8'h19: return 18'h00900;
      8'h29: return 18'h01100;
      8'h39: return 18'h02100;
      8'h59: return 18'h04100;
      8'h49: return 18'h08100;
      8'h79: return 18'h10100;
      8'h69: return 18'h20100;
      default: return 18'h00000;
    endcase
  endfunction
  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", name, obs, exp);
    end
  endtask
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    acc = nreset && in_valid && a_in_ready;
    if (nreset && a_out_valid && out_ready) begin
      tests++;
      assert (qa.size() != 0) else begin fails++; $error("FAIL sb_a unexpected output %h", a_out_packet); end
      if (qa.size() != 0) begin
        e = qa.pop_front();
        tests++;
        assert ({a_out_command, a_out_write, a_out_packet, a_out_decode} === e) else begin
          fails++;
          $error("FAIL sb_a got %h exp %h", {a_out_command, a_out_write, a_out_packet, a_out_decode}, e);
        end
      end
    end
    if (nreset && b_out_valid && out_ready) begin
      tests++;
      assert (qb.size() != 0) else begin fails++; $error("FAIL sb_b unexpected output %h", b_out_packet); end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        tests++;
        assert ({b_out_command, b_out_write, b_out_packet, b_out_decode} === e) else begin
          fails++;
          $error("FAIL sb_b got %h exp %h", {b_out_command, b_out_write, b_out_packet, b_out_decode}, e);
        end
      end
    end
    if (acc) begin
      e = {in_command, in_write, in_packet, exp_dec({in_command, in_write})};
      qa.push_back(e);
      if ({in_command, in_write} != 8'h00) qb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] op);
    {in_command, in_write} = op;
    for (int i = 0; i < 8; i++) in_packet[i*32 +: 32] = $urandom;
    in_valid = 1'b1;
  endtask
  task automatic wait_acc();
    int n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin tick(); n++; end
    chk("accept_bound", acc, 1);
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_decode", a_out_decode, 0);
    stat_sel = 3'd7;
    #1 chk("rst_cnt", a_cnt, 0);
    chk("rst_err", a_err, 0);
    nreset = 1'b1;
    tick();
    drive(8'h02);
    tick();
    chk("rd_acc", acc, 1);
    in_valid = 1'b0;
    chk("rd_latency", a_out_valid, 1);
    chk("rd_decode", a_out_decode, 18'h00002);
    stat_sel = 3'd0;
    #1 chk("rd_cnt0", a_cnt, 1);
    stat_sel = 3'd7;
    #1 chk("rd_cnt7", a_cnt, 1);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      drive(8'h01);
      tick();
      chk("posted_acc", acc, 1);
      chk("posted_in_ready", a_in_ready, 1);
      chk("posted_out_valid", a_out_valid, 1);
    end
    idle(2);
    stat_sel = 3'd1;
    #1 chk("posted_cnt1", a_cnt, 4);
    out_ready = 1'b0;
    drive(8'h02);
    tick();
    chk("stall_acc1", acc, 1);
    p1 = in_packet;
    drive(8'h02);
    tick();
    chk("stall_acc2", acc, 1);
    chk("stall_in_ready", a_in_ready, 0);
    drive(8'h02);
    repeat (3) begin
      tick();
      chk("stall_no_acc", acc, 0);
      chk("stall_valid", a_out_valid, 1);
      chk("stall_packet", a_out_packet, p1);
    end
    out_ready = 1'b1;
    wait_acc();
    idle(3);
    chk("stall_drained", qa.size(), 0);
    drive(8'h00);
    tick();
    chk("inv_acc", acc, 1);
    in_valid = 1'b0;
    chk("inv_fwd_a", a_out_valid, 1);
    chk("inv_drop_b", b_out_valid, 0);
    stat_sel = 3'd6;
    #1 chk("inv_cnt_a", a_cnt, 1);
    chk("inv_cnt_b", b_cnt, 1);
    chk("inv_err_a", a_err, 1);
    chk("inv_err_b", b_err, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("err_clear_b", b_err, 0);
    err_clear = 1'b1;
    drive(8'h00);
    tick();
    in_valid = 1'b0;
    err_clear = 1'b0;
    chk("err_clear_wins", b_err, 0);
    chk("inv_cnt_b2", b_cnt, 2);
    idle(2);
    for (int i = 0; i < 17; i++) begin
      drive(8'h09);
      tick();
      chk("add_acc", acc, 1);
      chk("add_decode_b", {b_out_decode[10], b_out_decode[8]}, 2'b11);
    end
    idle(2);
    stat_sel = 3'd5;
    #1 chk("sat_cnt_b", b_cnt, 4'hF);
    chk("add_cnt_a", a_cnt, 17);
    stat_clear = 1'b1;
    drive(8'h09);
    tick();
    chk("clr_acc", acc, 1);
    in_valid = 1'b0;
    stat_clear = 1'b0;
    chk("clr_wins_b", b_cnt, 0);
    chk("clr_wins_a", a_cnt, 0);
    stat_sel = 3'd7;
    #1 chk("clr_total", a_cnt, 0);
    idle(2);
    for (int i = 0; i < 18; i++) begin
      drive(ops[i]);
      tick();
      chk("table_acc", acc, 1);
    end
    idle(2);
    stat_sel = 3'd4;
    #1 chk("other_wr_cnt", a_cnt, 3);
    stat_sel = 3'd5;
    #1 chk("atomic_cnt", a_cnt, 8);
    stat_sel = 3'd3;
    #1 chk("wr_resp_cnt", a_cnt, 2);
    out_ready = 1'b0;
    drive(8'h02);
    tick();
    drive(8'h01);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", a_out_valid, 1);
    chk("pre_rst_full", a_in_ready, 0);
    stat_sel = 3'd7;
    #1 chk("pre_rst_total", a_cnt, 20);
    nreset = 1'b0;
    #1;
    chk("arst_valid_a", a_out_valid, 0);
    chk("arst_valid_b", b_out_valid, 0);
    chk("arst_in_ready", a_in_ready, 1);
    chk("arst_cnt_a", a_cnt, 0);
    chk("arst_cnt_b", b_cnt, 0);
    qa.delete();
    qb.delete();
    tick();
    nreset = 1'b1;
    out_ready = 1'b1;
    idle(3);
    chk("post_rst_idle", a_out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
